// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the cache/memory arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MEM_LAT_DEF = 4;
  localparam int unsigned CTR_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Load/decrement wait counter timing the memory access window.
module arb_wait_ctr #(
  parameter int unsigned CTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [CTR_W-1:0] ld_val,
  output logic             zero
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (ld)
      cnt <= ld_val;
    else if (cnt != '0)
      cnt <= cnt - CTR_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter for a single fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to port 0.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned CTR_W   = CTR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_strobe,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rdy,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_strobe,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rdy,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_strobe,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t        state, state_n;
  logic              win;
  logic              ld;
  logic              zero;
  logic              grant_n;
  logic              rdy0_n, rdy1_n, strobe_n, rw_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata0_n, rdata1_n;

  arb_wait_ctr #(.CTR_W(CTR_W)) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .ld_val (CTR_W'(MEM_LAT - 1)),
    .zero   (zero)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (ld)
      last_grant <= grant_n;
  end

  always_comb begin
    win = 1'b0;
    if (req0_strobe && req1_strobe)
      win = ~last_grant;
    else
      win = req1_strobe;
  end
`else
  always_comb begin
    win = 1'b0;
    win = ~req0_strobe;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state plus next values of every registered output; mem_* double as the request latch.
  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    grant_n  = grant_id;
    rdy0_n   = 1'b0;
    rdy1_n   = 1'b0;
    strobe_n = 1'b0;
    rw_n     = mem_rw;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    rdata0_n = req0_rdata;
    rdata1_n = req1_rdata;
    case (state)
      IDLE: begin
        if (req0_strobe || req1_strobe) begin
          state_n  = ACCESS;
          ld       = 1'b1;
          strobe_n = 1'b1;
          grant_n  = win;
          rw_n     = win ? req1_rw    : req0_rw;
          addr_n   = win ? req1_addr  : req0_addr;
          wdata_n  = win ? req1_wdata : req0_wdata;
        end
      end
      ACCESS: begin
        strobe_n = 1'b1;
        if (zero) begin
          state_n  = DONE;
          strobe_n = 1'b0;
          if (grant_id) begin
            rdy1_n = 1'b1;
            if (!mem_rw) rdata1_n = mem_rdata;
          end else begin
            rdy0_n = 1'b1;
            if (!mem_rw) rdata0_n = mem_rdata;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_strobe <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req0_rdy   <= 1'b0;
      req1_rdy   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      mem_strobe <= strobe_n;
      mem_rw     <= rw_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      req0_rdy   <= rdy0_n;
      req1_rdy   <= rdy1_n;
      req0_rdata <= rdata0_n;
      req1_rdata <= rdata1_n;
      busy       <= (state_n != IDLE);
      grant_id   <= grant_n;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (MEM_LAT=4 instance plus a MEM_LAT=1 instance).
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0s, r0rw, r1s, r1rw;
  logic [15:0] r0a, r1a;
  logic [31:0] r0w, r1w;
  logic        rdy0, rdy1, ms, mrw, busy, gid;
  logic [31:0] rd0, rd1, mw, mrd;
  logic [15:0] ma;

  logic        b_r0s, b_r0rw, b_r1s, b_r1rw;
  logic [15:0] b_r0a, b_r1a, b_ma;
  logic [31:0] b_r0w, b_r1w, b_rd0, b_rd1, b_mw, b_mrd;
  logic        b_rdy0, b_rdy1, b_ms, b_mrw, b_busy, b_gid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: one marked word, otherwise data derived from the address.
  assign mrd   = (ma == 16'h0040) ? 32'hDEADBEEF : {16'hA5A5, ma};
  assign b_mrd = {16'hA5A5, b_ma};

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(4), .CTR_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_strobe(r0s), .req0_rw(r0rw), .req0_addr(r0a), .req0_wdata(r0w),
    .req0_rdy(rdy0), .req0_rdata(rd0),
    .req1_strobe(r1s), .req1_rw(r1rw), .req1_addr(r1a), .req1_wdata(r1w),
    .req1_rdy(rdy1), .req1_rdata(rd1),
    .mem_strobe(ms), .mem_rw(mrw), .mem_addr(ma), .mem_wdata(mw), .mem_rdata(mrd),
    .busy(busy), .grant_id(gid)
  );

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .CTR_W(3)) dut_lat1 (
    .clk(clk), .reset(reset),
    .req0_strobe(b_r0s), .req0_rw(b_r0rw), .req0_addr(b_r0a), .req0_wdata(b_r0w),
    .req0_rdy(b_rdy0), .req0_rdata(b_rd0),
    .req1_strobe(b_r1s), .req1_rw(b_r1rw), .req1_addr(b_r1a), .req1_wdata(b_r1w),
    .req1_rdy(b_rdy1), .req1_rdata(b_rd1),
    .mem_strobe(b_ms), .mem_rw(b_mrw), .mem_addr(b_ma), .mem_wdata(b_mw), .mem_rdata(b_mrd),
    .busy(b_busy), .grant_id(b_gid)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    r0s = 0; r1s = 0; b_r0s = 0; b_r1s = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({ms, mrw, busy, gid, rdy0, rdy1} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 000000", {ms, mrw, busy, gid, rdy0, rdy1});
    end
    total++;
    if (ma !== 16'h0 || mw !== 32'h0) begin
      bad++; $display("FAIL reset_mem: got addr %h wdata %h want 0", ma, mw);
    end
    total++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0", rd0, rd1);
    end
    reset = 1'b0;
  endtask

  // Single access on the LAT=4 instance; strobe raised before grant edge k, sampled each negedge i (cycle k+i).
  task automatic run_access(input bit port, input bit rw, input logic [15:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rdata, input string nm);
    int scnt = 0, first_s = -1, rdy_at = -1, rdy_cnt = 0, other = 0, field_err = 0;
    logic [31:0] got_rd = 32'hX;
    logic        got_gid = 1'bx;
    @(negedge clk);
    if (port) begin r1s = 1; r1rw = rw; r1a = addr; r1w = wd; end
    else      begin r0s = 1; r0rw = rw; r0a = addr; r0w = wd; end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ms) begin
        scnt++;
        if (first_s < 0) first_s = i;
        if (mrw !== rw || ma !== addr || (rw && mw !== wd)) field_err++;
      end
      if (port ? rdy1 : rdy0) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at = i; got_rd = port ? rd1 : rd0; got_gid = gid;
        end
        if (port) r1s = 0; else r0s = 0;
      end
      if (port ? rdy0 : rdy1) other++;
    end
    total++;
    if (scnt !== 4 || first_s !== 1) begin
      bad++; $display("FAIL %s_strobe: got %0d cycles from %0d want 4 from 1", nm, scnt, first_s);
    end
    total++;
    if (rdy_at !== 5 || rdy_cnt !== 1) begin
      bad++; $display("FAIL %s_rdy: got cycle %0d count %0d want cycle 5 count 1", nm, rdy_at, rdy_cnt);
    end
    total++;
    if (got_rd !== exp_rdata) begin
      bad++; $display("FAIL %s_rdata: got %h want %h", nm, got_rd, exp_rdata);
    end
    total++;
    if (field_err !== 0 || other !== 0 || got_gid !== port) begin
      bad++; $display("FAIL %s_fields: got errs %0d other_rdy %0d gid %b want 0 0 %b",
                      nm, field_err, other, got_gid, port);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    run_access(1'b0, 1'b0, 16'h0040, 32'h0, 32'hDEADBEEF, "read0");
  endtask

  task automatic test_write();
    // Port 1 never read since reset, so rdata must still be 0.
    run_access(1'b1, 1'b1, 16'h0100, 32'h12345678, 32'h0, "write1");
  endtask

  task automatic test_tie();
    bit exp [4];
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int r = 0; r < 4; r++) begin
      logic got = 1'bx;
      @(negedge clk);
      r0s = 1; r0rw = 0; r0a = 16'h0200;
      r1s = 1; r1rw = 0; r1a = 16'h0300;
      for (int i = 1; i <= 10 && got === 1'bx; i++) begin
        @(negedge clk);
        if (rdy0 || rdy1) begin
          got = rdy1;
          r0s = 0; r1s = 0;
        end
      end
      total++;
      if (got !== exp[r]) begin
        bad++; $display("FAIL tie_round%0d: got port %b want %b", r, got, exp[r]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int at0 = -1, at1 = -1;
    logic [31:0] v0 = 32'hX, v1 = 32'hX;
    do_reset();
    @(negedge clk);
    r0s = 1; r0rw = 0; r0a = 16'h0010;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 2) begin r1s = 1; r1rw = 0; r1a = 16'h0020; end
      if (rdy0) begin if (at0 < 0) begin at0 = i; v0 = rd0; end r0s = 0; end
      if (rdy1) begin if (at1 < 0) begin at1 = i; v1 = rd1; end r1s = 0; end
    end
    total++;
    if (at0 !== 5 || at1 !== 11) begin
      bad++; $display("FAIL b2b_order: got rdy0@%0d rdy1@%0d want 5 and 11", at0, at1);
    end
    total++;
    if (v0 !== 32'hA5A50010 || v1 !== 32'hA5A50020) begin
      bad++; $display("FAIL b2b_rdata: got %h %h want a5a50010 a5a50020", v0, v1);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    do_reset();
    @(negedge clk);
    r0s = 1; r0rw = 0; r0a = 16'h0030;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    r0s = 0;
    #1;
    total++;
    if ({ms, busy, rdy0, rdy1} !== 4'b0) begin
      bad++; $display("FAIL midreset_clear: got %b want 0000", {ms, busy, rdy0, rdy1});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy0 || rdy1 || ms) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL midreset_stray: got %0d active cycles want 0", stray);
    end
    run_access(1'b0, 1'b0, 16'h0040, 32'h0, 32'hDEADBEEF, "after_reset");
  endtask

  task automatic test_lat1();
    int scnt = 0, rdy_at = -1;
    logic [31:0] v = 32'hX;
    do_reset();
    @(negedge clk);
    b_r0s = 1; b_r0rw = 0; b_r0a = 16'h0055;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b_ms) scnt++;
      if (b_rdy0) begin if (rdy_at < 0) begin rdy_at = i; v = b_rd0; end b_r0s = 0; end
    end
    total++;
    if (scnt !== 1 || rdy_at !== 2) begin
      bad++; $display("FAIL lat1_timing: got strobe %0d rdy@%0d want 1 and 2", scnt, rdy_at);
    end
    total++;
    if (v !== 32'hA5A50055) begin
      bad++; $display("FAIL lat1_rdata: got %h want a5a50055", v);
    end
  endtask

  initial begin
    reset = 1'b1;
    r0s = 0; r0rw = 0; r0a = '0; r0w = '0;
    r1s = 0; r1rw = 0; r1a = '0; r1w = '0;
    b_r0s = 0; b_r0rw = 0; b_r0a = '0; b_r0w = '0;
    b_r1s = 0; b_r1rw = 0; b_r1a = '0; b_r1w = '0;
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
